// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: boot > round-robin(data, instr), with boot lock.
// Optional MEM_PORT_ARBITER_RANGE_CHK_EN rejects addresses >= MEM_SIZE.
module mem_port_arbiter #(
    parameter int MEM_SIZE = 4096,
    parameter int AW       = $clog2(MEM_SIZE / 4)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_lock_i,

    input  logic          boot_req_i,
    input  logic          boot_we_i,
    input  logic [3:0]    boot_be_i,
    input  logic [31:0]   boot_addr_i,
    input  logic [31:0]   boot_wdata_i,
    output logic          boot_gnt_o,
    output logic          boot_rvalid_o,
    output logic [31:0]   boot_rdata_o,
    output logic          boot_err_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    input  logic          instr_req_i,
    input  logic          instr_we_i,
    input  logic [3:0]    instr_be_i,
    input  logic [31:0]   instr_addr_i,
    input  logic [31:0]   instr_wdata_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,

    output logic          lock_active_o
);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LOCK    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic [2:0]  src_q, src_d;
    logic        err_q, err_d;

    logic        boot_ok, cpu_ok;
    logic        gnt_b, gnt_d, gnt_i, any_gnt;
    logic        oor;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (boot_lock_i)  state_d = LOCK;
            LOCK:    if (!boot_lock_i) state_d = RELEASE;
            RELEASE: state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // A lock request in an ARB cycle already fences the CPU out.
    assign boot_ok = rst_n && (state_q != RELEASE);
    assign cpu_ok  = rst_n && (state_q == ARB) && !boot_lock_i;

    assign gnt_b   = boot_ok && boot_req_i;
    assign gnt_d   = cpu_ok && !boot_req_i && data_req_i
                     && (!instr_req_i || !rr_q);
    assign gnt_i   = cpu_ok && !boot_req_i && instr_req_i
                     && (!data_req_i || rr_q);
    assign any_gnt = gnt_b || gnt_d || gnt_i;

    always_comb begin
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (1'b1)
            gnt_b: begin
                sel_we    = boot_we_i;
                sel_be    = boot_be_i;
                sel_addr  = boot_addr_i;
                sel_wdata = boot_wdata_i;
            end
            gnt_d: begin
                sel_we    = data_we_i;
                sel_be    = data_be_i;
                sel_addr  = data_addr_i;
                sel_wdata = data_wdata_i;
            end
            gnt_i: begin
                sel_we    = 1'b0;
                sel_be    = instr_be_i;
                sel_addr  = instr_addr_i;
                sel_wdata = instr_wdata_i;
            end
            default: ;
        endcase
    end

`ifdef MEM_PORT_ARBITER_RANGE_CHK_EN
    assign oor = any_gnt && (sel_addr >= 32'(MEM_SIZE));
    logic unused_bits;
    assign unused_bits = ^{instr_we_i, sel_addr[1:0]};
`else
    assign oor = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{instr_we_i, sel_addr[1:0], sel_addr[31:AW+2]};
`endif

    assign mem_req_o   = any_gnt && !oor;
    assign mem_we_o    = mem_req_o && sel_we;
    assign mem_be_o    = sel_be;
    assign mem_addr_o  = sel_addr[AW+1:2];
    assign mem_wdata_o = sel_wdata;

    always_comb begin
        rr_d = rr_q;
        if (gnt_d) rr_d = 1'b1;
        if (gnt_i) rr_d = 1'b0;
    end

    assign src_d = {gnt_b, gnt_d, gnt_i};
    assign err_d = oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            rr_q    <= 1'b0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    assign rdata = err_q ? 32'h0 : mem_rdata_i;

    assign boot_gnt_o     = gnt_b;
    assign data_gnt_o     = gnt_d;
    assign instr_gnt_o    = gnt_i;

    assign boot_rvalid_o  = src_q[2];
    assign data_rvalid_o  = src_q[1];
    assign instr_rvalid_o = src_q[0];

    assign boot_rdata_o   = rdata;
    assign data_rdata_o   = rdata;
    assign instr_rdata_o  = rdata;

    assign boot_err_o     = src_q[2] && err_q;
    assign data_err_o     = src_q[1] && err_q;
    assign instr_err_o    = src_q[0] && err_q;

    assign lock_active_o  = (state_q != ARB);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM.
// Range-check expectations follow MEM_PORT_ARBITER_RANGE_CHK_EN.
module tb_mem_port_arbiter;

    localparam int MS = 4096;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boot_lock_i = 1'b0;

    logic boot_req_i = 0, boot_we_i = 0;
    logic [3:0] boot_be_i = 4'hF;
    logic [31:0] boot_addr_i = 0, boot_wdata_i = 0;
    logic boot_gnt_o, boot_rvalid_o, boot_err_o;
    logic [31:0] boot_rdata_o;

    logic data_req_i = 0, data_we_i = 0;
    logic [3:0] data_be_i = 4'hF;
    logic [31:0] data_addr_i = 0, data_wdata_i = 0;
    logic data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;

    logic instr_req_i = 0, instr_we_i = 0;
    logic [3:0] instr_be_i = 4'hF;
    logic [31:0] instr_addr_i = 0, instr_wdata_i = 0;
    logic instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;

    logic mem_req_o, mem_we_o;
    logic [3:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 0;
    logic lock_active_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n), .boot_lock_i(boot_lock_i),
        .boot_req_i(boot_req_i), .boot_we_i(boot_we_i),
        .boot_be_i(boot_be_i), .boot_addr_i(boot_addr_i),
        .boot_wdata_i(boot_wdata_i), .boot_gnt_o(boot_gnt_o),
        .boot_rvalid_o(boot_rvalid_o), .boot_rdata_o(boot_rdata_o),
        .boot_err_o(boot_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o),
        .instr_req_i(instr_req_i), .instr_we_i(instr_we_i),
        .instr_be_i(instr_be_i), .instr_addr_i(instr_addr_i),
        .instr_wdata_i(instr_wdata_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .instr_err_o(instr_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .lock_active_o(lock_active_o)
    );

    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b])
                        mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata_i <= mem[mem_addr_o];
            end
        end
    end

    wire [2:0] gv = {boot_gnt_o, data_gnt_o, instr_gnt_o};
    wire [2:0] rv = {boot_rvalid_o, data_rvalid_o, instr_rvalid_o};
    wire [2:0] ev = {boot_err_o, data_err_o, instr_err_o};

    typedef struct {
        logic       b;
        logic       d;
        logic       i;
        logic       lk;
        logic [2:0] eg;
        logic [2:0] erv;
        logic       ela;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        boot_req_i = 0;
        data_req_i = 0;
        instr_req_i = 0;
        boot_we_i = 0;
        data_we_i = 0;
    endtask

    task automatic do_read(input int p, input logic [31:0] a,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic exp_mreq, input string nm);
        logic [2:0] oh;
        logic [31:0] rd;
        oh = 3'b100 >> p;
        idle();
        case (p)
            0: begin boot_req_i = 1; boot_addr_i = a; end
            1: begin data_req_i = 1; data_addr_i = a; end
            default: begin instr_req_i = 1; instr_addr_i = a; end
        endcase
        #4;
        chk({nm, " gnt"}, 32'(gv), 32'(oh));
        chk({nm, " mem_req"}, 32'(mem_req_o), 32'(exp_mreq));
        if (exp_mreq)
            chk({nm, " mem_addr"}, 32'(mem_addr_o), 32'(a[AW+1:2]));
        tick();
        idle();
        #4;
        case (p)
            0: rd = boot_rdata_o;
            1: rd = data_rdata_o;
            default: rd = instr_rdata_o;
        endcase
        chk({nm, " rvalid"}, 32'(rv), 32'(oh));
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " err"}, 32'(ev), exp_err ? 32'(oh) : 32'h0);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0] = 32'hA5A5_0000;
        mem[4] = 32'hDEAD_BEEF;

        // b d i lk  gnt    rvalid  lock_active
        vec[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b0};
        vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 3'b010, 1'b0};
        vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b001, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 3'b100, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 3'b010, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 3'b001, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'b010, 1'b0};
        vec[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'b100, 1'b1};
        vec[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 3'b100, 1'b1};
        vec[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b1};
        vec[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1};
        vec[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0};

        #12;
        chk("rst gnt", 32'(gv), 32'h0);
        chk("rst rvalid", 32'(rv), 32'h0);
        chk("rst err", 32'(ev), 32'h0);
        chk("rst mem_req", 32'({mem_req_o, mem_we_o}), 32'h0);
        chk("rst lock_active", 32'(lock_active_o), 32'h0);
        tick();
        rst_n = 1;
        tick();

        do_read(1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, "rd data");
        do_read(2, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, "rd instr");
        do_read(0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, "rd boot");

        idle();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'hF;
        data_addr_i = 32'h20; data_wdata_i = 32'h1234_5678;
        #4;
        chk("b2b wr gnt", 32'(gv), 32'b010);
        chk("b2b mem_we", 32'(mem_we_o), 32'h1);
        tick();
        idle();
        instr_req_i = 1; instr_addr_i = 32'h20;
        #4;
        chk("b2b rd gnt", 32'(gv), 32'b001);
        chk("b2b wr rvalid", 32'(rv), 32'b010);
        chk("b2b wr err", 32'(data_err_o), 32'h0);
        tick();
        idle();
        #4;
        chk("b2b rd rvalid", 32'(rv), 32'b001);
        chk("b2b rd rdata", instr_rdata_o, 32'h1234_5678);
        tick();

        data_addr_i = 32'h10; instr_addr_i = 32'h14;
        boot_we_i = 1; boot_addr_i = 32'h400; boot_wdata_i = 32'h55AA_55AA;
        for (int k = 0; k < 16; k++) begin
            boot_req_i = vec[k].b;
            boot_we_i = 1;
            data_req_i = vec[k].d;
            instr_req_i = vec[k].i;
            boot_lock_i = vec[k].lk;
            #4;
            chk($sformatf("vec%0d gnt", k), 32'(gv), 32'(vec[k].eg));
            chk($sformatf("vec%0d rvalid", k), 32'(rv), 32'(vec[k].erv));
            chk($sformatf("vec%0d lock", k), 32'(lock_active_o),
                32'(vec[k].ela));
            tick();
        end

        idle();
        data_req_i = 1; data_addr_i = 32'h10;
        #4;
        chk("mid gnt", 32'(gv), 32'b010);
        tick();
        idle();
        rst_n = 0;
        #4;
        chk("mid rst rvalid", 32'(rv), 32'h0);
        chk("mid rst outs", 32'({gv, mem_req_o, mem_we_o, lock_active_o}),
            32'h0);
        tick();
        rst_n = 1;
        #4;
        chk("mid post rvalid", 32'(rv), 32'h0);
        tick();
        data_req_i = 1; instr_req_i = 1;
        #4;
        chk("mid first gnt", 32'(gv), 32'b010);
        tick();
        idle();
        tick();

`ifdef MEM_PORT_ARBITER_RANGE_CHK_EN
        do_read(1, 32'h1000, 32'h0, 1'b1, 1'b0, "range");
`else
        do_read(1, 32'h1000, 32'hA5A5_0000, 1'b0, 1'b1, "range");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
